// File: rtl/minterm_lut_if.sv
// Handshake bundle for the minterm LUT engine: table load, evaluation and ON-set count.
// The engine uses the slave modport; the stimulus driver uses master.
interface minterm_lut_if #(
    parameter int N_IN = 7,
    parameter int W    = 8
);
    localparam int CW = N_IN + 1;

    logic            load_start;
    logic            load_valid;
    logic [W-1:0]    load_data;
    logic            load_ready;
    logic            in_valid;
    logic [N_IN-1:0] in_vec;
    logic            in_ready;
    logic            out_valid;
    logic            out;
    logic            cnt_start;
    logic            cnt_done;
    logic [CW-1:0]   cnt_value;
    logic            table_valid;

    modport master (
        output load_start, load_valid, load_data, in_valid, in_vec, cnt_start,
        input  load_ready, in_ready, out_valid, out, cnt_done, cnt_value, table_valid
    );

    modport slave (
        input  load_start, load_valid, load_data, in_valid, in_vec, cnt_start,
        output load_ready, in_ready, out_valid, out, cnt_done, cnt_value, table_valid
    );
endinterface

// File: rtl/minterm_lut_engine.sv
// Run-time programmable N-input Boolean function: word-serial truth-table load,
// 1-cycle registered evaluation, and a full-table scan that counts the ON-set.
module minterm_lut_engine #(
    parameter int N_IN = 7,
    parameter int W    = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    minterm_lut_if.slave bus
);
    localparam int DEPTH  = 1 << N_IN;
    localparam int NWORDS = DEPTH / W;
    localparam int CW     = N_IN + 1;
    localparam int PW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic [1:0] {EMPTY, LOADING, READY, SCAN} state_t;

    state_t          state_q, state_d;
    logic [DEPTH-1:0] table_q, table_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [N_IN-1:0] scan_addr_q, scan_addr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            cnt_done_q, cnt_done_d;
    logic            out_q, out_d;
    logic            out_valid_q, out_valid_d;

    logic            eval_fire;
    logic            load_fire;
    logic            last_word;

    assign bus.load_ready  = (state_q == LOADING);
    assign bus.in_ready    = (state_q == READY);
    assign bus.table_valid = (state_q == READY) || (state_q == SCAN);
    assign bus.out_valid   = out_valid_q;
    assign bus.out         = out_q;
    assign bus.cnt_done    = cnt_done_q;
    assign bus.cnt_value   = cnt_q;

    // A load_start in LOADING restarts the load, so its same-cycle word is discarded.
    assign eval_fire = bus.in_valid && (state_q == READY);
    assign load_fire = bus.load_valid && (state_q == LOADING) && !bus.load_start;
    assign last_word = (ptr_q == PW'(NWORDS - 1));

    always_comb begin
        state_d     = state_q;
        table_d     = table_q;
        ptr_d       = ptr_q;
        scan_addr_d = scan_addr_q;
        cnt_d       = cnt_q;
        cnt_done_d  = 1'b0;
        out_valid_d = 1'b0;
        out_d       = out_q;

        if (eval_fire) begin
            out_valid_d = 1'b1;
            out_d       = table_q[bus.in_vec];
        end

        if (load_fire) begin
            table_d[int'(ptr_q) * W +: W] = bus.load_data;
        end

        case (state_q)
            EMPTY: begin
                if (bus.load_start) begin
                    ptr_d   = '0;
                    state_d = LOADING;
                end
            end
            LOADING: begin
                if (bus.load_start) begin
                    ptr_d = '0;
                end else if (load_fire) begin
                    if (last_word) begin
                        ptr_d   = '0;
                        state_d = READY;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            READY: begin
                if (bus.load_start) begin
                    ptr_d   = '0;
                    state_d = LOADING;
                end else if (bus.cnt_start) begin
                    cnt_d       = '0;
                    scan_addr_d = '0;
                    state_d     = SCAN;
                end
            end
            SCAN: begin
                // The address only wraps on the final read, which is also the exit cycle.
                cnt_d       = cnt_q + CW'(table_q[scan_addr_q]);
                scan_addr_d = scan_addr_q + 1'b1;
                if (scan_addr_q == '1) begin
                    cnt_done_d = 1'b1;
                    state_d    = READY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            table_q     <= '0;
            ptr_q       <= '0;
            scan_addr_q <= '0;
            cnt_q       <= '0;
            cnt_done_q  <= 1'b0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            table_q     <= table_d;
            ptr_q       <= ptr_d;
            scan_addr_q <= scan_addr_d;
            cnt_q       <= cnt_d;
            cnt_done_q  <= cnt_done_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_minterm_lut_engine.sv
// Self-checking bench for minterm_lut_engine (N_IN=7, W=8) using a truth-table
// reference held as a plain 128-bit vector.
module tb_minterm_lut_engine;
    localparam int N_IN   = 7;
    localparam int W      = 8;
    localparam int DEPTH  = 128;
    localparam int NWORDS = 16;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;
    logic [DEPTH-1:0] ref_tbl;

    minterm_lut_if #(.N_IN(N_IN), .W(W)) bus ();

    minterm_lut_engine #(.N_IN(N_IN), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int popcount(input logic [DEPTH-1:0] t);
        int s = 0;
        for (int i = 0; i < DEPTH; i++) s += int'(t[i]);
        return s;
    endfunction

    // Loads tbl word by word; gaps randomises load_valid and pokes cnt_start mid-load.
    task automatic load_words(input logic [DEPTH-1:0] tbl, input bit gaps);
        int k = 0;
        int cyc = 0;
        bus.load_start = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_data  = 8'hFF;
        tick();
        bus.load_start = 1'b0;
        tests_run++;
        if ({bus.load_ready, bus.table_valid, bus.in_ready} !== 3'b100) begin
            tests_failed++;
            $display("[TB] FAIL load_enter: got %b expected 100", {bus.load_ready, bus.table_valid, bus.in_ready});
        end
        while (k < NWORDS && cyc < 400) begin
            bus.load_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.cnt_start  = gaps && (k == 3);
            bus.load_data  = tbl[k*W +: W];
            tick();
            if (bus.load_valid) k++;
            cyc++;
            if (k < NWORDS) begin
                tests_run++;
                if ({bus.load_ready, bus.table_valid} !== 2'b10) begin
                    tests_failed++;
                    $display("[TB] FAIL load_busy: word %0d got %b expected 10", k, {bus.load_ready, bus.table_valid});
                end
            end
        end
        bus.load_valid = 1'b0;
        bus.cnt_start  = 1'b0;
        tests_run++;
        if ({bus.load_ready, bus.table_valid, bus.in_ready} !== 3'b011 || k != NWORDS) begin
            tests_failed++;
            $display("[TB] FAIL load_done: got %b after %0d words expected 011 after 16",
                     {bus.load_ready, bus.table_valid, bus.in_ready}, k);
        end
        ref_tbl = tbl;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.load_start = 1'b0; bus.load_valid = 1'b0; bus.load_data = '0;
        bus.in_valid = 1'b0; bus.in_vec = '0; bus.cnt_start = 1'b0;
        #23;
        tests_run++;
        if ({bus.load_ready, bus.in_ready, bus.out_valid, bus.out, bus.cnt_done, bus.cnt_value, bus.table_valid} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got %b expected all zero",
                     {bus.load_ready, bus.in_ready, bus.out_valid, bus.out, bus.cnt_done, bus.cnt_value, bus.table_valid});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_eval();
        logic [DEPTH-1:0] t = '0;
        for (int k = 0; k < NWORDS; k++) t[k*W] = 1'b1;
        load_words(t, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_vec   = 7'd8;
        tick();
        tests_run++;
        if ({bus.out_valid, bus.out} !== 2'b11) begin
            tests_failed++;
            $display("[TB] FAIL eval_vec8: got %b expected 11", {bus.out_valid, bus.out});
        end
        bus.in_vec = 7'd9;
        tick();
        tests_run++;
        if ({bus.out_valid, bus.out} !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL eval_vec9: got %b expected 10", {bus.out_valid, bus.out});
        end
        bus.in_valid = 1'b0;
        bus.in_vec   = 7'd8;
        tick();
        tests_run++;
        if ({bus.out_valid, bus.out} !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL eval_idle_hold: got %b expected 00", {bus.out_valid, bus.out});
        end
    endtask

    // inject pulses load_start, cnt_start and in_valid partway through the scan.
    task automatic test_count(input bit inject);
        int n = 0;
        int dones = 0;
        int exp_cnt = popcount(ref_tbl);
        logic [N_IN:0] held;
        bus.cnt_start = 1'b1;
        tick();
        bus.cnt_start = 1'b0;
        while (bus.in_ready === 1'b0 && n < 300) begin
            if (bus.cnt_done === 1'b1) dones++;
            tests_run++;
            if ({bus.out_valid, bus.load_ready, bus.table_valid} !== 3'b001) begin
                tests_failed++;
                $display("[TB] FAIL scan_flags: cycle %0d got %b expected 001", n,
                         {bus.out_valid, bus.load_ready, bus.table_valid});
            end
            bus.load_start = inject && (n == 30);
            bus.cnt_start  = inject && (n == 30);
            bus.in_valid   = inject && (n == 30);
            bus.in_vec     = 7'($urandom_range(0, DEPTH - 1));
            tick();
            n++;
        end
        bus.load_start = 1'b0; bus.cnt_start = 1'b0; bus.in_valid = 1'b0;
        tests_run++;
        if (n != DEPTH || dones != 0) begin
            tests_failed++;
            $display("[TB] FAIL scan_len: got %0d cycles, %0d early done expected 128, 0", n, dones);
        end
        tests_run++;
        if (bus.cnt_done !== 1'b1 || bus.cnt_value !== 8'(exp_cnt)) begin
            tests_failed++;
            $display("[TB] FAIL scan_count: got done=%b value=%0d expected done=1 value=%0d",
                     bus.cnt_done, bus.cnt_value, exp_cnt);
        end
        held = bus.cnt_value;
        tick();
        tests_run++;
        if (bus.cnt_done !== 1'b0 || bus.cnt_value !== 8'(exp_cnt) || bus.in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL scan_after: got done=%b value=%0d ready=%b expected 0, %0d, 1",
                     bus.cnt_done, bus.cnt_value, bus.in_ready, held);
        end
    endtask

    task automatic test_back_to_back();
        bus.in_valid = 1'b1;
        bus.in_vec   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            tests_run++;
            if (bus.out_valid !== 1'b1 || bus.out !== ref_tbl[i]) begin
                tests_failed++;
                $display("[TB] FAIL b2b_eval: vec %0d got valid=%b out=%b expected 1, %b",
                         i, bus.out_valid, bus.out, ref_tbl[i]);
            end
            bus.in_vec = 7'(i + 1);
        end
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_load_restart();
        logic [DEPTH-1:0] a = {$urandom, $urandom, $urandom, $urandom};
        logic [DEPTH-1:0] b = ~a;
        int k = 0;
        int cyc = 0;
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        while (k < 6 && cyc < 50) begin
            bus.load_valid = (cyc % 2 == 0);
            bus.load_data  = a[k*W +: W];
            tick();
            if (bus.load_valid) k++;
            cyc++;
        end
        bus.load_valid = 1'b0;
        tests_run++;
        if ({bus.load_ready, bus.table_valid} !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL restart_mid: got %b expected 10", {bus.load_ready, bus.table_valid});
        end
        load_words(b, 1'b1);
    endtask

    task automatic test_random_eval();
        logic exp_valid = 1'b0;
        logic exp_out = bus.out;
        for (int i = 0; i < 200; i++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_vec   = 7'($urandom_range(0, DEPTH - 1));
            exp_valid    = bus.in_valid;
            if (bus.in_valid) exp_out = ref_tbl[bus.in_vec];
            tick();
            tests_run++;
            if (bus.out_valid !== exp_valid || bus.out !== exp_out) begin
                tests_failed++;
                $display("[TB] FAIL rand_eval: step %0d got valid=%b out=%b expected %b, %b",
                         i, bus.out_valid, bus.out, exp_valid, exp_out);
            end
        end
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_scan();
        bus.cnt_start = 1'b1;
        tick();
        bus.cnt_start = 1'b0;
        repeat (59) tick();
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bus.load_ready, bus.in_ready, bus.out_valid, bus.out, bus.cnt_done, bus.cnt_value, bus.table_valid} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL midscan_reset: got %b expected all zero",
                     {bus.load_ready, bus.in_ready, bus.out_valid, bus.out, bus.cnt_done, bus.cnt_value, bus.table_valid});
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_vec    = 7'($urandom_range(0, DEPTH - 1));
            bus.cnt_start = (i == 2);
            tick();
            tests_run++;
            if ({bus.out_valid, bus.in_ready, bus.table_valid, bus.cnt_done} !== 4'b0000) begin
                tests_failed++;
                $display("[TB] FAIL empty_ignore: step %0d got %b expected 0000", i,
                         {bus.out_valid, bus.in_ready, bus.table_valid, bus.cnt_done});
            end
        end
        bus.in_valid  = 1'b0;
        bus.cnt_start = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        ref_tbl      = '0;
        test_reset();
        test_basic_eval();
        test_count(1'b0);
        load_words({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        test_back_to_back();
        test_load_restart();
        test_back_to_back();
        test_count(1'b1);
        load_words({DEPTH{1'b1}}, 1'b1);
        test_count(1'b0);
        load_words({DEPTH{1'b0}}, 1'b0);
        test_count(1'b1);
        load_words({$urandom, $urandom, $urandom, $urandom}, 1'b1);
        test_random_eval();
        test_reset_mid_scan();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/minterm_lut_engine.md
Name: minterm_lut_engine

Overview:
- Programmable N-input Boolean function evaluator. The truth table (one bit per minterm) is loaded word-serially at run time, so the function is not fixed in logic.
- Evaluates input vectors with registered output.
- Provides a scan mode that walks every minterm and counts the ON-set, used to check a loaded function's minterm count against its expected value.
- Sits behind the lab's config/stimulus driver and replaces hard-wired sum-of-minterms blocks.

Parameters:
- N_IN, 7, number of function inputs; table depth is 2^N_IN bits.
- W, 8, load word width; power of two, 1 <= W <= 2^N_IN.
- Derived, not overridable: NWORDS = 2^N_IN / W; CW = N_IN+1 (count width).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- load_start  in  1  pulse: invalidate table, begin new load.
- load_valid  in  1  load word present.
- load_data  in  W  truth-table word; bit j of word k is minterm k*W+j.
- load_ready  out  1  high only in LOADING.
- in_valid  in  1  evaluation request.
- in_vec  in  N_IN  input vector; bit N_IN-1 is the MSB of the minterm index.
- in_ready  out  1  high only in READY.
- out_valid  out  1  result strobe.
- out  out  1  function value for the accepted in_vec.
- cnt_start  in  1  pulse: start ON-set count.
- cnt_done  out  1  one-cycle pulse: count complete.
- cnt_value  out  CW  number of ON minterms.
- table_valid  out  1  full table loaded.

Behaviour:
- Reset (asynchronous, rst_n=0), any state including mid-load or mid-scan:
  - state = EMPTY; all table bits = 0; word pointer = 0; scan address = 0.
  - All outputs 0, including cnt_value.
- FSM states: EMPTY, LOADING, READY, SCAN.
- load_start:
  - Accepted in EMPTY, LOADING or READY: pointer <= 0, table_valid <= 0, state -> LOADING.
  - Table bits are not cleared; they are overwritten.
  - Ignored in SCAN.
  - In LOADING it restarts the load from word 0; a same-cycle load_valid is discarded.
- Load transfer:
  - Occurs when load_valid && load_ready: table[ptr*W +: W] <= load_data; ptr++.
  - On the transfer of word NWORDS-1: state -> READY and table_valid = 1 from the next cycle.
  - load_valid gaps are legal; the pointer holds through them.
- Evaluation:
  - Transfer occurs when in_valid && in_ready.
  - Next cycle: out_valid = 1 and out = table[in_vec]. Latency is exactly 1 cycle; throughput is 1 per cycle.
  - out holds its last value when out_valid = 0.
  - in_valid outside READY is dropped, with no out_valid.
- cnt_start:
  - Accepted only in READY; ignored elsewhere.
  - On acceptance: cnt_value <= 0, scan address <= 0, state -> SCAN.
  - If in_valid is also high in that cycle, the eval is accepted and its result appears next cycle as normal.
- SCAN:
  - Lasts exactly 2^N_IN cycles, reading addresses 0 .. 2^N_IN-1, one per cycle.
  - Accumulator adds table[addr]; it never overflows because CW = N_IN+1.
  - in_ready = 0 and load_ready = 0 throughout.
  - The cycle after the last address is read: cnt_done = 1 for one cycle, cnt_value is final, state -> READY.
  - cnt_value holds until the next accepted cnt_start or reset.
- Edge cases:
  - Scan address wraps only on exit; no scan starts in EMPTY or LOADING.
  - table_valid stays 1 during SCAN.
- W == 2^N_IN: a single-word load; READY is reached after one transfer.

Test Plan:
- Reset, then N_IN=7, W=8: load 16 words each 8'h01 -> table_valid rises the cycle after the 16th transfer; in_vec=7'd8 -> out=1 one cycle later; in_vec=7'd9 -> out=0.
- Same table, cnt_start -> in_ready=0 for 128 cycles, cnt_done pulses once, cnt_value=16; all-ones table -> cnt_value=128; all-zero table -> cnt_value=0.
- Back-to-back eval of in_vec 0..127 with in_valid held high -> 128 consecutive out_valid, each out matching the loaded bit, no bubbles.
- load_valid toggling 1/0 during load, plus load_start after word 5 -> load restarts at word 0; table_valid only after 16 further transfers; data matches the second load.
- rst_n low at scan cycle 60 -> all outputs 0 immediately, state EMPTY; in_valid then has no effect until a reload.
- cnt_start and load_start pulsed in LOADING or SCAN -> ignored; scan still completes at 128 cycles with the correct count.
